// File: rtl/alu_pkg.sv
// Shared encodings, widths and single-cycle datapath for the ALU execute block.
package alu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_MUL  = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_WB   = 2'd2
  } state_e;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= 4'(OP_MUL);
  endfunction

  // Combinational result for every op except MUL, which goes to mul_iter.
  function automatic logic [XLEN-1:0] alu_calc(input logic [3:0] op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [4:0] sh;
    logic [XLEN-1:0] res;
    sh  = b[4:0];
    res = '0;
    case (alu_op_e'(op))
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_SLL:  res = a << sh;
      OP_SRL:  res = a >> sh;
      OP_SRA:  res = $unsigned($signed(a) >>> sh);
      OP_SLT:  res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: res = {{(XLEN-1){1'b0}}, a < b};
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Operand bundle handshake and register-file writeback signals of alu_exec.
import alu_pkg::*;

interface alu_exec_if;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [RW-1:0]   rd;
  logic            wb_en;
  logic [RW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            zero;
  logic            illegal;
  logic            busy;

  modport master (
    output in_valid, alu_op, op_a, op_b, rd,
    input  in_ready, wb_en, wb_addr, wb_data, zero, illegal, busy
  );

  modport slave (
    input  in_valid, alu_op, op_a, op_b, rd,
    output in_ready, wb_en, wb_addr, wb_data, zero, illegal, busy
  );
endinterface

// File: rtl/alu_exec_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, 32 cycles per start.
import alu_pkg::*;

module mul_iter (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] product
);

  logic [XLEN-1:0] acc, mcand, mplier;
  logic [RW-1:0]   cnt;
  logic            run;
  logic [XLEN-1:0] acc_next;

  assign acc_next = mplier[0] ? acc + mcand : acc;
  // Product includes the final step so the caller can register it on done.
  assign done     = run && (cnt == '1);
  assign product  = acc_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      run    <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
      cnt    <= '0;
      run    <= 1'b1;
    end else if (run) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (cnt == '1) run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// ALU execute stage: single-cycle ops write back next cycle, MUL after 32 busy cycles.
import alu_pkg::*;

module alu_exec (
  input logic      clk,
  input logic      reset,
  alu_exec_if.slave bus
);

  state_e          state_q, state_d;
  logic            xfer, legal, is_mul, start_mul, mul_done;
  logic [XLEN-1:0] mul_prod, alu_res;
  logic [RW-1:0]   rd_q;

  assign legal   = op_legal(bus.alu_op);
  assign is_mul  = (bus.alu_op == 4'(OP_MUL));
  assign alu_res = alu_calc(bus.alu_op, bus.op_a, bus.op_b);

  mul_iter u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (start_mul),
    .a       (bus.op_a),
    .b       (bus.op_b),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    bus.in_ready = (state_q != S_MUL);
    bus.busy     = (state_q == S_MUL);
    xfer         = bus.in_valid && bus.in_ready;
    start_mul    = 1'b0;
    case (state_q)
      S_IDLE, S_WB: begin
        if (xfer) begin
          if (is_mul) begin
            state_d   = S_MUL;
            start_mul = 1'b1;
          end else if (legal) begin
            state_d = S_WB;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL:   if (mul_done) state_d = S_WB;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.wb_en   <= 1'b0;
      bus.wb_addr <= '0;
      bus.wb_data <= '0;
      bus.zero    <= 1'b0;
      bus.illegal <= 1'b0;
      rd_q        <= '0;
    end else begin
      bus.wb_en   <= 1'b0;
      bus.zero    <= 1'b0;
      bus.illegal <= 1'b0;
      if (start_mul) rd_q <= bus.rd;
      if (state_q == S_MUL && mul_done) begin
        bus.wb_en   <= (rd_q != '0);
        bus.wb_addr <= rd_q;
        bus.wb_data <= mul_prod;
        bus.zero    <= (mul_prod == '0);
      end else if (xfer && legal && !is_mul) begin
        bus.wb_en   <= (bus.rd != '0);
        bus.wb_addr <= bus.rd;
        bus.wb_data <= alu_res;
        bus.zero    <= (alu_res == '0);
      end else if (xfer && !legal) begin
        bus.illegal <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec with hand-computed expectations.
module tb_alu_exec;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  alu_exec_if bus ();

  alu_exec dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bundle(input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] r);
    bus.in_valid = 1'b1;
    bus.alu_op   = op;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.rd       = r;
  endtask

  // Presents one bundle for one edge; afterwards the bench is in cycle N+1.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] r);
    set_bundle(op, a, b, r);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic check_wb(input string tag, input logic en, input logic [4:0] addr,
                          input logic [31:0] data, input logic z);
    check({tag, ".wb_en"},   32'(bus.wb_en),   32'(en));
    check({tag, ".wb_addr"}, 32'(bus.wb_addr), 32'(addr));
    check({tag, ".wb_data"}, bus.wb_data,      data);
    check({tag, ".zero"},    32'(bus.zero),    32'(z));
  endtask

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.alu_op   = '0;
    bus.op_a     = '0;
    bus.op_b     = '0;
    bus.rd       = '0;
    step(); step(); step();

    check_wb("rst", 1'b0, 5'd0, 32'd0, 1'b0);
    check("rst.illegal",  32'(bus.illegal),  0);
    check("rst.busy",     32'(bus.busy),     0);
    check("rst.in_ready", 32'(bus.in_ready), 1);
    reset = 1'b0;
    step();

    do_op(4'd0, 32'd10, 32'd20, 5'd1);
    check_wb("add", 1'b1, 5'd1, 32'd30, 1'b0);
    check("add.in_ready", 32'(bus.in_ready), 1);
    step();
    check_wb("add.hold", 1'b0, 5'd1, 32'd30, 1'b0);

    do_op(4'd1, 32'd10, 32'd30, 5'd2);
    check_wb("sub", 1'b1, 5'd2, 32'hFFFF_FFEC, 1'b0);
    step();
    do_op(4'd8, 32'hFFFF_FFFB, 32'd3, 5'd3);
    check_wb("slt", 1'b1, 5'd3, 32'd1, 1'b0);
    step();
    do_op(4'd9, 32'hFFFF_FFFB, 32'd3, 5'd3);
    check_wb("sltu", 1'b1, 5'd3, 32'd0, 1'b1);
    step();
    do_op(4'd7, 32'h8000_0000, 32'd4, 5'd4);
    check_wb("sra", 1'b1, 5'd4, 32'hF800_0000, 1'b0);
    step();
    do_op(4'd6, 32'h8000_0000, 32'd4, 5'd4);
    check_wb("srl", 1'b1, 5'd4, 32'h0800_0000, 1'b0);
    step();
    do_op(4'd5, 32'd1, 32'h0000_0023, 5'd4);
    check_wb("sll.shamt", 1'b1, 5'd4, 32'd8, 1'b0);
    step();
    do_op(4'd0, 32'hFFFF_FFFF, 32'd1, 5'd5);
    check_wb("add.wrap", 1'b1, 5'd5, 32'd0, 1'b1);
    step();
    do_op(4'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd6);
    check_wb("and", 1'b1, 5'd6, 32'h00F0_1200, 1'b0);
    step();
    do_op(4'd3, 32'hF000_0001, 32'h0000_0F00, 5'd6);
    check_wb("or", 1'b1, 5'd6, 32'hF000_0F01, 1'b0);
    step();

    // MUL with a different bundle held upstream during the busy window.
    do_op(4'd10, 32'd300, 32'd30, 5'd14);
    set_bundle(4'd0, 32'd7, 32'd8, 5'd5);
    for (int i = 1; i <= 32; i++) begin
      check($sformatf("mul.busy@%0d", i),     32'(bus.busy),     1);
      check($sformatf("mul.in_ready@%0d", i), 32'(bus.in_ready), 0);
      check($sformatf("mul.wb_en@%0d", i),    32'(bus.wb_en),    0);
      step();
    end
    check_wb("mul", 1'b1, 5'd14, 32'd9000, 1'b0);
    check("mul.busy_end", 32'(bus.busy),     0);
    check("mul.ready_end", 32'(bus.in_ready), 1);
    step();
    bus.in_valid = 1'b0;
    check_wb("held_add", 1'b1, 5'd5, 32'd15, 1'b0);
    step();
    check("held_add.done", 32'(bus.wb_en), 0);

    set_bundle(4'd0, 32'd1, 32'd2, 5'd6);
    step();
    check_wb("b2b.0", 1'b1, 5'd6, 32'd3, 1'b0);
    set_bundle(4'd0, 32'd3, 32'd4, 5'd7);
    step();
    check_wb("b2b.1", 1'b1, 5'd7, 32'd7, 1'b0);
    set_bundle(4'd0, 32'd5, 32'd6, 5'd8);
    step();
    bus.in_valid = 1'b0;
    check_wb("b2b.2", 1'b1, 5'd8, 32'd11, 1'b0);
    step();
    check("b2b.end", 32'(bus.wb_en), 0);

    do_op(4'd10, 32'd3, 32'd4, 5'd9);
    for (int i = 1; i < 10; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_wb("mulrst", 1'b0, 5'd0, 32'd0, 1'b0);
    check("mulrst.busy",    32'(bus.busy),     0);
    check("mulrst.illegal", 32'(bus.illegal),  0);
    check("mulrst.ready",   32'(bus.in_ready), 1);
    for (int i = 0; i < 40; i++) begin
      check($sformatf("mulrst.no_wb@%0d", i), 32'(bus.wb_en), 0);
      step();
    end

    set_bundle(4'd0, 32'd1, 32'd1, 5'd4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    check_wb("rst_prio", 1'b0, 5'd0, 32'd0, 1'b0);
    step();
    check("rst_prio.later", 32'(bus.wb_en), 0);

    do_op(4'd1, 32'd9, 32'd2, 5'd10);
    check_wb("pre_xor", 1'b1, 5'd10, 32'd7, 1'b0);
    do_op(4'd4, 32'd5, 32'd5, 5'd0);
    check_wb("xor.r0", 1'b0, 5'd0, 32'd0, 1'b1);
    do_op(4'd12, 32'd1, 32'd2, 5'd3);
    check("ill.pulse", 32'(bus.illegal), 1);
    check_wb("ill", 1'b0, 5'd0, 32'd0, 1'b0);
    step();
    check("ill.end", 32'(bus.illegal), 0);
    check("ill.wb_en", 32'(bus.wb_en), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1, operand/op bundle valid (operands come from register file dout1/dout2).
REQ-004 SHALL have port in_ready, output, 1, block accepts bundle this cycle.
REQ-005 SHALL have port alu_op, input, 4, operation code.
REQ-006 SHALL have port op_a, input, 32, first operand (register file dout1).
REQ-007 SHALL have port op_b, input, 32, second operand (register file dout2).
REQ-008 SHALL have port rd, input, 5, destination register address.
REQ-009 SHALL have port wb_en, output, 1, write strobe to register file wren.
REQ-010 SHALL have port wb_addr, output, 5, write address to register file addrw.
REQ-011 SHALL have port wb_data, output, 32, write data to register file din.
REQ-012 SHALL have port zero, output, 1, high when wb_data == 0 during a writeback cycle.
REQ-013 SHALL have port illegal, output, 1, one-cycle pulse for an unsupported alu_op.
REQ-014 SHALL have port busy, output, 1, high while a multiply is in progress.

Function
REQ-015 SHALL support ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed, result 1/0), 9 SLTU (unsigned), 10 MUL (low 32 bits of product).
REQ-016 SHALL treat alu_op 11-15 as illegal: bundle accepted, no writeback, illegal pulses in cycle N+1.
REQ-017 SHALL use arithmetic modulo 2^32; carry/overflow discarded; shift amount = op_b[4:0].
REQ-018 SHALL implement FSM states IDLE, MUL, WB; a transfer occurs when in_valid && in_ready.
REQ-019 SHALL drive in_ready high in IDLE and WB and low in MUL.
REQ-020 SHALL, for a single-cycle op accepted in cycle N, be in WB in cycle N+1 with wb_en=1, wb_addr=rd and wb_data=result.
REQ-021 SHALL, for MUL accepted in cycle N, occupy MUL for cycles N+1..N+32 (5-bit counter 0..31) and be in WB in cycle N+33.
REQ-022 SHALL, from WB, go to the next op's state if a transfer occurs in that cycle, else go to IDLE; back-to-back single-cycle ops sustain one writeback per cycle.
REQ-023 SHALL suppress wb_en when rd == 0 (r0 never written); wb_data is still computed.
REQ-024 SHALL hold wb_en at 0 outside WB; wb_addr and wb_data hold their last values.
REQ-025 SHALL ignore in_valid while in MUL; the upstream bundle is held until in_ready.
REQ-026 SHALL latch op_a, op_b, rd and alu_op at transfer; later input changes have no effect.

Reset
REQ-027 SHALL, on reset, set state=IDLE, wb_en=0, wb_addr=0, wb_data=0, zero=0, illegal=0, busy=0 and counter=0.
REQ-028 SHALL, on reset during MUL or WB, abort the operation with no writeback in any later cycle.
REQ-029 SHALL take reset priority over a simultaneous transfer; the bundle is dropped.

Structure
REQ-030 SHALL place alu_op encodings, FSM state encoding and the 32/5-bit width constants in shared package alu_pkg.
REQ-031 SHALL implement the iterative shift-add multiplier as sub-module mul_iter (start, done, 32-cycle latency).

Verification
REQ-032 SHALL check ADD op_a=10, op_b=20, rd=1 accepted cycle N -> cycle N+1: wb_en=1, wb_addr=1, wb_data=30, zero=0.
REQ-033 SHALL check SUB 10-30, rd=2 -> wb_data=0xFFFFFFEC; SLT result=1; SLTU result=0.
REQ-034 SHALL check MUL 300*30, rd=14 at cycle N -> busy N+1..N+32, in_ready=0 there, wb_data=9000 only at N+33.
REQ-035 SHALL check three back-to-back ADDs -> three consecutive wb_en cycles with correct data/addresses.
REQ-036 SHALL check reset asserted at N+10 of a MUL -> no wb_en ever; all outputs 0 on the next cycle.
REQ-037 SHALL check XOR 5^5, rd=0 -> wb_en=0, zero=1; alu_op=12 -> illegal pulse at N+1, no wb_en.
